param_up_down_counter: RTL and testbench

//   Parametrised up/down counter; successor to the fixed 4-bit up/down counter.

---
 rtl/param_up_down_counter_pkg.sv | 23 ++
 rtl/param_up_down_counter_step.sv | 71 +++++++
 rtl/param_up_down_counter.sv | 107 ++++++++++
 tb/tb_param_up_down_counter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/param_up_down_counter_pkg.sv
// ============================================================================
// Module      : param_up_down_counter_pkg
// Description : Shared counting-mode encodings and helpers for the
//               parametrised up/down counter and its step logic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package param_up_down_counter_pkg;

    // Counting behaviour once the count reaches a limit in its direction
    localparam int MODE_WRAP   = 0;
    localparam int MODE_SAT    = 1;
    localparam int MODE_BOUNCE = 2;

    // True when a MODE parameter value names one of the supported behaviours
    function automatic bit mode_is_valid(input int mode);
        return (mode == MODE_WRAP) || (mode == MODE_SAT) || (mode == MODE_BOUNCE);
    endfunction

endpackage

`default_nettype wire

// File: rtl/param_up_down_counter_step.sv
// ============================================================================
// Module      : param_up_down_counter_step
// Description : Combinational next-count, next-direction and limit-event
//               logic for one enabled counting step.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_up_down_counter_step
    import param_up_down_counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_VALUE = 15,
    parameter int MODE      = MODE_WRAP
) (
    input  logic [WIDTH-1:0] q,
    input  logic             dir,
    output logic [WIDTH-1:0] q_step,
    output logic             dir_step,
    output logic             limit_event
);

    // One extra bit so MAX_VALUE = 2**WIDTH-1 and the +1/-1 steps never alias
    localparam logic [WIDTH:0] c_max_ext    = (WIDTH+1)'(MAX_VALUE);
    localparam logic [WIDTH:0] c_one_ext    = (WIDTH+1)'(1);
    localparam logic [WIDTH:0] c_max_m1_ext = c_max_ext - c_one_ext;

    logic [WIDTH:0] w_q_ext;
    logic [WIDTH:0] w_up_ext;
    logic [WIDTH:0] w_dn_ext;
    logic [WIDTH:0] w_next_ext;
    logic           w_at_top;
    logic           w_at_bot;
    logic           w_unused_msb;

    assign w_q_ext  = {1'b0, q};
    assign w_up_ext = w_q_ext + c_one_ext;
    assign w_dn_ext = w_q_ext - c_one_ext;
    assign w_at_top = (w_q_ext == c_max_ext);
    assign w_at_bot = (w_q_ext == '0);

    // A limit event is a step that would leave the 0..MAX_VALUE range
    assign limit_event = dir ? w_at_bot : w_at_top;

    // Plain +/-1 step unless at the limit, where the mode decides what happens
    always_comb begin
        w_next_ext = dir ? w_dn_ext : w_up_ext;
        dir_step   = dir;
        if (limit_event) begin
            case (MODE)
                MODE_SAT: begin
                    w_next_ext = w_q_ext;
                end
                MODE_BOUNCE: begin
                    w_next_ext = dir ? c_one_ext : c_max_m1_ext;
                    dir_step   = ~dir;
                end
                default: begin
                    w_next_ext = dir ? c_max_ext : '0;
                end
            endcase
        end
    end

    // In-range results never set the extra bit; it only exists for headroom
    assign q_step       = w_next_ext[WIDTH-1:0];
    assign w_unused_msb = w_next_ext[WIDTH];

endmodule

`default_nettype wire

// File: rtl/param_up_down_counter.sv
// ============================================================================
// Module      : param_up_down_counter
// Description : Parametrised up/down counter with programmable width and
//               modulus, parallel load, wrap/saturate/bounce limit modes,
//               limit flags and a registered terminal-count pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_up_down_counter
    import param_up_down_counter_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int MAX_VALUE   = (1 << WIDTH) - 1,
    parameter int MODE        = MODE_WRAP,
    parameter int RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             go_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] q_next,
    output logic             at_max,
    output logic             at_min,
    output logic             terminal,
    output logic             dir_down
);

    localparam logic [WIDTH:0]   c_max_ext   = (WIDTH+1)'(MAX_VALUE);
    localparam logic [WIDTH-1:0] c_max_val   = WIDTH'(MAX_VALUE);
    localparam logic [WIDTH-1:0] c_reset_val = WIDTH'(RESET_VALUE);
    localparam bit               c_bounce    = (MODE == MODE_BOUNCE);

    // Reject parameter sets that cannot describe a sensible counter
    generate
        if (MAX_VALUE >= (1 << WIDTH)) begin : g_chk_max_fits
            $error("param_up_down_counter: MAX_VALUE must be below 2**WIDTH");
        end
        if (MAX_VALUE < 1) begin : g_chk_max_min
            $error("param_up_down_counter: MAX_VALUE must be at least 1");
        end
        if ((RESET_VALUE > MAX_VALUE) || (RESET_VALUE < 0)) begin : g_chk_reset
            $error("param_up_down_counter: RESET_VALUE must lie in 0..MAX_VALUE");
        end
        if (!mode_is_valid(MODE)) begin : g_chk_mode
            $error("param_up_down_counter: MODE must be 0, 1 or 2");
        end
    endgenerate

    logic [WIDTH-1:0] r_q;
    logic             r_dir;
    logic             r_terminal;

    logic             w_dir_eff;
    logic [WIDTH-1:0] w_step_q;
    logic             w_step_dir;
    logic             w_limit_event;
    logic [WIDTH-1:0] w_load_clamped;

    // Bounce owns its direction; the other modes follow go_down directly
    assign w_dir_eff = c_bounce ? r_dir : go_down;

    // Loads above the modulus saturate to MAX_VALUE rather than truncating
    assign w_load_clamped = ({1'b0, load_value} > c_max_ext) ? c_max_val : load_value;

    param_up_down_counter_step #(
        .WIDTH     (WIDTH),
        .MAX_VALUE (MAX_VALUE),
        .MODE      (MODE)
    ) u_step (
        .q           (r_q),
        .dir         (w_dir_eff),
        .q_step      (w_step_q),
        .dir_step    (w_step_dir),
        .limit_event (w_limit_event)
    );

    // Count, direction and terminal registers with reset > load > enable > hold
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q        <= c_reset_val;
            r_dir      <= 1'b0;
            r_terminal <= 1'b0;
        end else if (load) begin
            r_q        <= w_load_clamped;
            r_dir      <= c_bounce ? go_down : 1'b0;
            r_terminal <= 1'b0;
        end else if (enable) begin
            r_q        <= w_step_q;
            r_dir      <= c_bounce ? w_step_dir : 1'b0;
            r_terminal <= w_limit_event;
        end else begin
            r_terminal <= 1'b0;
        end
    end

    assign q_next   = r_q;
    assign at_max   = ({1'b0, r_q} == c_max_ext);
    assign at_min   = (r_q == '0);
    assign terminal = r_terminal;
    assign dir_down = w_dir_eff;

endmodule

`default_nettype wire

// File: tb/tb_param_up_down_counter.sv
// ============================================================================
// Module      : tb_param_up_down_counter
// Description : Self-checking bench for param_up_down_counter. Four instances
//               (wrap/9, saturate/15, bounce/3, wrap/255 on 8 bits) share one
//               stimulus stream; a behavioural model checks all of them every
//               cycle and directed literal checks pin individual scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_param_up_down_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       go_down = 1'b0;
    logic       load = 1'b0;
    logic [7:0] lv = 8'd0;

    logic [3:0] q0, q1, q2;
    logic [7:0] q3;
    logic [3:0] mx, mn, tm, dd;
    logic [7:0] dq [4];

    always #5 clk = ~clk;

    // Instance configuration seen by the model
    localparam int P_MAX  [4] = '{9, 15, 3, 255};
    localparam int P_MODE [4] = '{0, 1, 2, 0};
    localparam int P_RST  [4] = '{0, 5, 0, 0};
    localparam int P_MASK [4] = '{15, 15, 15, 255};

    param_up_down_counter #(.WIDTH(4), .MAX_VALUE(9), .MODE(0), .RESET_VALUE(0)) u_wrap (
        .clk(clk), .reset(reset), .enable(enable), .go_down(go_down), .load(load),
        .load_value(lv[3:0]), .q_next(q0), .at_max(mx[0]), .at_min(mn[0]),
        .terminal(tm[0]), .dir_down(dd[0]));

    param_up_down_counter #(.WIDTH(4), .MAX_VALUE(15), .MODE(1), .RESET_VALUE(5)) u_sat (
        .clk(clk), .reset(reset), .enable(enable), .go_down(go_down), .load(load),
        .load_value(lv[3:0]), .q_next(q1), .at_max(mx[1]), .at_min(mn[1]),
        .terminal(tm[1]), .dir_down(dd[1]));

    param_up_down_counter #(.WIDTH(4), .MAX_VALUE(3), .MODE(2), .RESET_VALUE(0)) u_bnc (
        .clk(clk), .reset(reset), .enable(enable), .go_down(go_down), .load(load),
        .load_value(lv[3:0]), .q_next(q2), .at_max(mx[2]), .at_min(mn[2]),
        .terminal(tm[2]), .dir_down(dd[2]));

    param_up_down_counter #(.WIDTH(8), .MAX_VALUE(255), .MODE(0), .RESET_VALUE(0)) u_w8 (
        .clk(clk), .reset(reset), .enable(enable), .go_down(go_down), .load(load),
        .load_value(lv), .q_next(q3), .at_max(mx[3]), .at_min(mn[3]),
        .terminal(tm[3]), .dir_down(dd[3]));

    assign dq[0] = {4'd0, q0};
    assign dq[1] = {4'd0, q1};
    assign dq[2] = {4'd0, q2};
    assign dq[3] = q3;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int mq   [4];
    bit mdir [4];
    bit mterm[4];
    bit mvalid = 1'b0;

    function automatic bit eff_dir(input int i);
        return (P_MODE[i] == 2) ? mdir[i] : go_down;
    endfunction

    function automatic bit at_limit(input int i);
        return eff_dir(i) ? (mq[i] == 0) : (mq[i] == P_MAX[i]);
    endfunction

    function automatic int nxt_q(input int i);
        int v;
        if (reset) return P_RST[i];
        if (load) begin
            v = int'(lv) & P_MASK[i];
            return (v > P_MAX[i]) ? P_MAX[i] : v;
        end
        if (!enable) return mq[i];
        if (!at_limit(i)) return eff_dir(i) ? mq[i] - 1 : mq[i] + 1;
        case (P_MODE[i])
            1:       return mq[i];
            2:       return eff_dir(i) ? 1 : P_MAX[i] - 1;
            default: return eff_dir(i) ? P_MAX[i] : 0;
        endcase
    endfunction

    function automatic bit nxt_dir(input int i);
        if (reset) return 1'b0;
        if (load) return (P_MODE[i] == 2) ? go_down : 1'b0;
        if (enable && P_MODE[i] == 2 && at_limit(i)) return ~mdir[i];
        return mdir[i];
    endfunction

    function automatic bit nxt_term(input int i);
        if (reset || load || !enable) return 1'b0;
        return at_limit(i);
    endfunction

    // Compare DUT against model, then advance model with the inputs the next edge samples
    always @(negedge clk) begin
        if (mvalid) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("cyc_q[%0d]", i),    int'(dq[i]), mq[i]);
                check($sformatf("cyc_term[%0d]", i), int'(tm[i]), int'(mterm[i]));
                check($sformatf("cyc_max[%0d]", i),  int'(mx[i]), int'(mq[i] == P_MAX[i]));
                check($sformatf("cyc_min[%0d]", i),  int'(mn[i]), int'(mq[i] == 0));
                check($sformatf("cyc_dir[%0d]", i),  int'(dd[i]),
                      int'((P_MODE[i] == 2) ? mdir[i] : go_down));
            end
        end
        for (int i = 0; i < 4; i++) begin
            mq[i]    <= nxt_q(i);
            mdir[i]  <= nxt_dir(i);
            mterm[i] <= nxt_term(i);
        end
        mvalid <= mvalid | reset;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int t1_q   [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        int t1d_q  [3]  = '{1, 0, 9};
        int t1d_t  [3]  = '{0, 0, 1};
        int t3_q   [8]  = '{1, 2, 3, 2, 1, 0, 1, 2};
        int t3_d   [8]  = '{0, 0, 0, 1, 1, 1, 0, 0};
        int t3_t   [8]  = '{0, 0, 0, 1, 0, 0, 1, 0};

        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("rst_q_wrap", int'(q0), 0);
        check("rst_q_sat", int'(q1), 5);
        check("rst_term", int'(tm[0]), 0);
        check("rst_at_min", int'(mn[0]), 1);
        check("rst_dir_bnc", int'(dd[2]), 0);

        // Wrap up through 9->0, then down through 0->9
        enable = 1'b1; go_down = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            check("t1_up_q", int'(q0), t1_q[k]);
            check("t1_up_term", int'(tm[0]), (k == 9) ? 1 : 0);
        end
        go_down = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t1_dn_q", int'(q0), t1d_q[k]);
            check("t1_dn_term", int'(tm[0]), t1d_t[k]);
        end
        check("model_pin_wrap", mq[0], 9);

        // Saturate at the top from 14, then at the bottom from 1
        enable = 1'b0; go_down = 1'b0; load = 1'b1; lv = 8'd14;
        tick();
        load = 1'b0;
        check("t2_load", int'(q1), 14);
        enable = 1'b1;
        tick(); check("t2_q1", int'(q1), 15); check("t2_t1", int'(tm[1]), 0);
        tick(); check("t2_q2", int'(q1), 15); check("t2_t2", int'(tm[1]), 1);
        tick(); check("t2_q3", int'(q1), 15); check("t2_t3", int'(tm[1]), 1);
        check("t2_at_max", int'(mx[1]), 1);
        enable = 1'b0; load = 1'b1; lv = 8'd1; go_down = 1'b1;
        tick();
        load = 1'b0; enable = 1'b1;
        tick(); check("t2_dn_q1", int'(q1), 0); check("t2_dn_t1", int'(tm[1]), 0);
        tick(); check("t2_dn_q2", int'(q1), 0); check("t2_dn_t2", int'(tm[1]), 1);
        check("t2_at_min", int'(mn[1]), 1);

        // Bounce between 0 and 3
        reset = 1'b1; enable = 1'b0; go_down = 1'b0;
        tick();
        reset = 1'b0; enable = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("t3_q", int'(q2), t3_q[k]);
            check("t3_dir", int'(dd[2]), t3_d[k]);
            check("t3_term", int'(tm[2]), t3_t[k]);
        end
        check("model_pin_bnc", mq[2], 2);

        // Priority: reset beats load and enable; load beats enable; load clamps
        reset = 1'b1; load = 1'b1; lv = 8'd7; enable = 1'b1;
        tick();
        check("t4_rst_q", int'(q0), 0);
        check("t4_rst_q_sat", int'(q1), 5);
        reset = 1'b0;
        tick();
        check("t4_load_q", int'(q0), 7);
        check("t4_load_term", int'(tm[0]), 0);
        check("t4_load_clamp_bnc", int'(q2), 3);
        lv = 8'd12;
        tick();
        check("t4_clamp_q", int'(q0), 9);
        check("t4_noclamp_sat", int'(q1), 12);

        // Reset while bouncing downwards
        lv = 8'd3; go_down = 1'b1; load = 1'b1; enable = 1'b0;
        tick();
        check("t5_load_dir", int'(dd[2]), 1);
        load = 1'b0; enable = 1'b1;
        tick();
        check("t5_down_q", int'(q2), 2);
        reset = 1'b1;
        tick();
        check("t5_rst_q", int'(q2), 0);
        check("t5_rst_dir", int'(dd[2]), 0);
        reset = 1'b0;
        tick();
        check("t5_after_q", int'(q2), 1);

        // 8-bit wrap at 255
        load = 1'b1; lv = 8'd254; go_down = 1'b0; enable = 1'b0;
        tick();
        load = 1'b0; enable = 1'b1;
        tick();
        check("w8_q255", int'(q3), 255);
        check("w8_at_max", int'(mx[3]), 1);
        tick();
        check("w8_wrap_q", int'(q3), 0);
        check("w8_wrap_term", int'(tm[3]), 1);

        // Toggling enable with random direction, occasional load and reset
        for (int k = 0; k < 400; k++) begin
            enable  = ~enable;
            go_down = 1'($urandom_range(0, 1));
            load    = ($urandom_range(0, 15) == 0);
            lv      = 8'($urandom_range(0, 255));
            reset   = ($urandom_range(0, 63) == 0);
            tick();
        end

        reset = 1'b0; load = 1'b0; enable = 1'b0;
        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
